// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - size, state and lane-mask encodings for the data-memory responder
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  localparam logic [3:0] LM_BYTE = 4'b0001;
  localparam logic [3:0] LM_HALF = 4'b0011;
  localparam logic [3:0] LM_WORD = 4'b1111;
endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane enables, store shift and load extract for one access
// MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of aligning them down.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);
  logic [1:0]  off;
  logic [3:0]  mask;
  logic [31:0] keep;

  always_comb begin
    off        = 2'b00;
    mask       = LM_WORD;
    misalign_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        off  = addr_i;
        mask = LM_BYTE;
      end
      SZ_HALF: begin
        off  = {addr_i[1], 1'b0};
        mask = LM_HALF;
`ifdef MISALIGN_TRAP_EN
        misalign_o = addr_i[0];
`endif
      end
      SZ_WORD, 2'b11: begin
        off  = 2'b00;
        mask = LM_WORD;
`ifdef MISALIGN_TRAP_EN
        misalign_o = |addr_i;
`endif
      end
    endcase
  end

  assign keep    = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  assign be_o    = misalign_o ? 4'b0000 : (mask << off);
  assign wdata_o = wdata_i << {off, 3'b000};
  assign rdata_o = misalign_o ? 32'h0 : ((rword_i >> {off, 3'b000}) & keep);
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with WAIT_CYCLES wait states and byte lanes
// MISALIGN_TRAP_EN (in dmem_lane_align) turns misaligned accesses into rsp_err responses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int AW    = IDX_W + 2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [AW-1:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          from_req, enter_resp, mem_we;
  logic          cur_we;
  logic [AW-1:0] cur_addr;
  logic [1:0]    cur_size;
  logic [31:0]   cur_wdata;
  logic [IDX_W-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wdata_sh, rd_lane;
  logic          misalign;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^req_addr[ADDR_W-1:AW];

  // With no wait states RESP is entered on the accept edge, so work from the live request.
  assign from_req  = (state_q == ST_IDLE);
  assign cur_we    = from_req ? req_we              : we_q;
  assign cur_addr  = from_req ? req_addr[AW-1:0]    : addr_q;
  assign cur_size  = from_req ? req_size            : size_q;
  assign cur_wdata = from_req ? req_wdata           : wdata_q;
  assign idx       = cur_addr[AW-1:2];

  dmem_lane_align u_align (
    .addr_i    (cur_addr[1:0]),
    .size_i    (cur_size),
    .wdata_i   (cur_wdata),
    .rword_i   (mem_q[idx]),
    .be_o      (be),
    .wdata_o   (wdata_sh),
    .rdata_o   (rd_lane),
    .misalign_o(misalign)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (enter_resp) begin
      rsp_rdata_d = cur_we ? 32'h0 : rd_lane;
      rsp_err_d   = misalign;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= 2'b00;
      wdata_q     <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (from_req && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr[AW-1:0];
        size_q  <= req_size;
        wdata_q <= req_wdata;
      end
    end
  end

  // Memory is deliberately outside the reset domain; contents survive reset.
  assign mem_we = enter_resp && cur_we && reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that sits on the far side of the processor's load/store port and answers core-initiated requests.
- Each request uses a valid/ready handshake. Each response is returned after a configurable number of wait states.
- Supports byte, half-word and word accesses with byte-lane enables.
- Lets the processor be exercised against a memory with realistic, non-zero latency instead of an ideal combinational one.

Parameters:
- ADDR_W, 32, byte-address width.
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of two, at least 4.
- WAIT_CYCLES, 2, wait states between accept and response; legal range 0..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- req_valid  in  1  request valid from the core.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load data, right-aligned, zero-extended; the core performs sign extension.
- rsp_err  out  1  misaligned-access error; tied to 0 when MISALIGN_TRAP_EN is not defined.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, wait counter = 0, captured request cleared.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, req_ready = 1 once reset is released.
  - Memory contents are NOT cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, capture we/addr/size/wdata.
  - Next state is WAIT with counter = WAIT_CYCLES-1 if WAIT_CYCLES > 0; otherwise RESP.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle; at 0, go to RESP.
- Entry into RESP (same edge):
  - Stores write only the enabled byte lanes.
  - Loads register the aligned lane data into rsp_rdata. For stores, rsp_rdata = 0.
- RESP:
  - rsp_valid = 1.
  - rsp_rdata and rsp_err stay stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE and drop rsp_valid on that edge.
  - The next request cannot be accepted before IDLE, so req_valid is ignored outside IDLE.
- Latency: accept edge to rsp_valid high is WAIT_CYCLES+1 cycles. Minimum request spacing is WAIT_CYCLES+2 cycles when rsp_ready is held high.
- Addressing:
  - Word index = req_addr[log2(DEPTH_WORDS)+1:2].
  - Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Lanes:
  - byte: lane = addr[1:0].
  - half: lanes {addr[1],0} and {addr[1],1}.
  - word: all four lanes.
- Load data is shifted down to bit 0; unused upper bits are 0.
- Core holds req_* stable while req_valid && !req_ready; the responder does not check this.
- Reset mid-operation:
  - Abandons the transaction.
  - A store captured but not yet at RESP entry is NOT written.
  - No response is issued.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0] = 1, or a word/size-11 access with addr[1:0] != 0, is misaligned.
  - A misaligned access performs no write and returns rsp_rdata = 0 with rsp_err = 1, at the same latency as a normal access.
- Undefined:
  - rsp_err is constant 0.
  - Half accesses ignore addr[0] and word accesses ignore addr[1:0], so they are silently aligned down.

Decomposition:
- Package dmem_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state enum (IDLE/WAIT/RESP).
  - Lane-mask constants.
- Sub-module dmem_lane_align (combinational):
  - Inputs: addr[1:0] and size.
  - Outputs: 4-bit byte enable, write-data lane shift, read-data extract, misalign flag.
- Top level holds the FSM, counter and memory array.

Test Plan:
1. Reset = 0 for 3 cycles mid-WAIT of a store sw 0xDEADBEEF to 0x10 -> no response; after release, a load of word 0x10 returns the prior value (initial 0), rsp_valid rises 3 cycles after accept (WAIT_CYCLES = 2).
2. Store word 0x11223344 @0x20, then load byte @0x21 -> rsp_rdata = 0x00000033; load half @0x22 -> 0x00001122.
3. Store byte 0xAA @0x23 over 0x11223344 -> word read @0x20 = 0xAA223344; other lanes are unchanged.
4. Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid stays 1, rsp_rdata stable, req_ready = 0, and a new req_valid is ignored; the response completes once rsp_ready goes high.
5. WAIT_CYCLES = 0 build: back-to-back loads with rsp_ready = 1 -> accept every 2 cycles, rsp_valid 1 cycle after accept. Address 0x400 + 0x20 (DEPTH_WORDS = 256) aliases to 0x20.
6. With MISALIGN_TRAP_EN, store word @0x22 -> rsp_err = 1, rsp_rdata = 0, memory unchanged. Without the macro, the same store writes the word @0x20 and rsp_err = 0.
